mem_bus_responder: RTL and testbench

//   Memory-side responder for the CPU bus (MAR/MBR_W/write out of CPU, MBR_R back into it).

---
 rtl/mem_bus_responder_pkg.sv | 30 +++
 rtl/mem_bus_responder_if.sv | 23 ++
 rtl/mem_word_array.sv | 26 ++
 rtl/mem_bus_responder.sv | 104 ++++++++++
 tb/tb_mem_bus_responder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared types, memory-map constants and helpers for the CPU-side memory responder.
package mem_bus_responder_pkg;

    localparam int unsigned BITS_DATA       = 32;
    localparam int unsigned BITS_ADDR       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef logic [BITS_DATA-1:0] data_t;
    typedef logic [BITS_ADDR-1:0] addr_t;

    // Memory map: RAM below IO_BASE, MMIO window from IO_BASE to the top.
    localparam addr_t IO_BASE     = 16'hFFF0;
    localparam addr_t ADDR_IO_OUT = 16'hFFF0;
    localparam addr_t ADDR_IO_IN  = 16'hFFF1;
    localparam addr_t ADDR_CYCLES = 16'hFFF2;
    localparam addr_t ADDR_STORES = 16'hFFF3;

    localparam int unsigned RAM_DEPTH = 32'(IO_BASE);

    typedef struct packed {
        logic  en;
        addr_t addr;
        data_t data;
    } ramWrReq_t;

    function automatic logic isRam(input addr_t addr);
        return addr < IO_BASE;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU memory bus: address/store data/write strobe out of the CPU, read data back in.
interface mem_bus_responder_if;

    mem_bus_responder_pkg::addr_t MAR;
    mem_bus_responder_pkg::data_t MBR_W;
    logic                         write;
    mem_bus_responder_pkg::data_t MBR_R;

    modport master (
        output MAR,
        output MBR_W,
        output write,
        input  MBR_R
    );

    modport slave (
        input  MAR,
        input  MBR_W,
        input  write,
        output MBR_R
    );

endinterface

// File: rtl/mem_word_array.sv
// Word RAM with one combinational read port and one synchronous write port.
module mem_word_array
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH = RAM_DEPTH
) (
    input  logic      clk,
    input  ramWrReq_t wrReq,
    input  addr_t     rdAddr,
    output data_t     rdData_c
);

    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

    data_t mem [DEPTH];

    // Contents are deliberately not reset so a preloaded program survives CPU reset.
    always_ff @(posedge clk) begin
        if (wrReq.en && (wrReq.addr <= LAST_ADDR)) begin
            mem[wrReq.addr] <= wrReq.data;
        end
    end

    assign rdData_c = (rdAddr <= LAST_ADDR) ? mem[rdAddr] : '0;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: word RAM, MMIO window (OUT, synchronised IN, counters) and a boot loader port.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_bus_responder_if.slave        bus,
    input  logic                      load_en,
    input  addr_t                     load_addr,
    input  data_t                     load_data,
    input  data_t                     io_in,
    output data_t                     io_out,
    output logic                      io_out_valid
);

    logic                         writeQ;
    logic                         wrFire;
    logic                         loadHit;
    logic                         cpuRamStore;
    logic                         outStore;
    data_t                        cycleCnt;
    data_t                        storeCnt;
    data_t [SYNC_STAGES-1:0]      syncChain;
    data_t                        syncOut;
    data_t                        ramRdData;
    data_t                        rdData;
    ramWrReq_t                    ramWrReq;

    // Store decode: one store per rising edge of the level write strobe; loader wins RAM conflicts.
    always_comb begin
        wrFire      = bus.write & ~writeQ & ~reset;
        loadHit     = load_en & isRam(load_addr);
        cpuRamStore = wrFire & isRam(bus.MAR) & ~loadHit;
        outStore    = wrFire & (bus.MAR == ADDR_IO_OUT);
    end

    always_comb begin
        ramWrReq = '0;
        if (loadHit) begin
            ramWrReq.en   = 1'b1;
            ramWrReq.addr = load_addr;
            ramWrReq.data = load_data;
        end else begin
            ramWrReq.en   = cpuRamStore;
            ramWrReq.addr = bus.MAR;
            ramWrReq.data = bus.MBR_W;
        end
    end

    mem_word_array #(
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk      (clk),
        .wrReq    (ramWrReq),
        .rdAddr   (bus.MAR),
        .rdData_c (ramRdData)
    );

    // writeQ resets high so a strobe held across reset cannot fire on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            writeQ       <= 1'b1;
            io_out       <= '0;
            io_out_valid <= 1'b0;
            cycleCnt     <= '0;
            storeCnt     <= '0;
            syncChain    <= '0;
        end else begin
            writeQ       <= bus.write;
            io_out_valid <= outStore;
            cycleCnt     <= cycleCnt + data_t'(1);
            syncChain    <= {syncChain[SYNC_STAGES-2:0], io_in};
            if (outStore) begin
                io_out <= bus.MBR_W;
            end
            if (cpuRamStore || outStore) begin
                storeCnt <= storeCnt + data_t'(1);
            end
        end
    end

    assign syncOut = syncChain[SYNC_STAGES-1];

    // Zero-latency read mux; unmapped MMIO reads as zero.
    always_comb begin
        rdData = '0;
        if (isRam(bus.MAR)) begin
            rdData = ramRdData;
        end else begin
            case (bus.MAR)
                ADDR_IO_OUT: rdData = io_out;
                ADDR_IO_IN:  rdData = syncOut;
                ADDR_CYCLES: rdData = cycleCnt;
                ADDR_STORES: rdData = storeCnt;
                default:     rdData = '0;
            endcase
        end
    end

    assign bus.MBR_R = rdData;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder against a spec-level behavioural model.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    localparam int unsigned SYNC = SYNC_STAGES_DEF;

    logic  clk = 1'b0;
    logic  reset;
    logic  load_en;
    addr_t load_addr;
    data_t load_data;
    data_t io_in;
    data_t io_out;
    logic  io_out_valid;

    int unsigned checkCnt = 0;
    int unsigned errCnt   = 0;

    mem_bus_responder_if bus ();

    mem_bus_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .io_in        (io_in),
        .io_out       (io_out),
        .io_out_valid (io_out_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    data_t mRam [int];
    data_t mIoOut;
    logic  mValid;
    data_t mCycles;
    data_t mStores;
    logic  mPrevWrite;
    data_t ioHist [$];

    function automatic bit expRead(input addr_t a, output data_t v);
        v = '0;
        if (a < IO_BASE) begin
            if (mRam.exists(int'(a))) begin
                v = mRam[int'(a)];
                return 1'b1;
            end
            return 1'b0;
        end
        if (a == ADDR_IO_OUT)      v = mIoOut;
        else if (a == ADDR_IO_IN)  v = (ioHist.size() == SYNC) ? ioHist[0] : '0;
        else if (a == ADDR_CYCLES) v = mCycles;
        else if (a == ADDR_STORES) v = mStores;
        return 1'b1;
    endfunction

    // Advance model by one edge using the inputs currently applied, then clock the DUT.
    task automatic step();
        bit loadOk;
        bit fire;
        loadOk = load_en && (load_addr < IO_BASE);
        if (loadOk) mRam[int'(load_addr)] = load_data;
        if (reset) begin
            mCycles = '0; mStores = '0; mIoOut = '0; mValid = 1'b0; mPrevWrite = 1'b1;
            ioHist.delete();
        end else begin
            fire   = bus.write && !mPrevWrite;
            mValid = 1'b0;
            if (fire) begin
                if (bus.MAR < IO_BASE) begin
                    if (!loadOk) begin
                        mRam[int'(bus.MAR)] = bus.MBR_W;
                        mStores = mStores + 1;
                    end
                end else if (bus.MAR == ADDR_IO_OUT) begin
                    mIoOut  = bus.MBR_W;
                    mStores = mStores + 1;
                    mValid  = 1'b1;
                end
            end
            mCycles    = mCycles + 1;
            mPrevWrite = bus.write;
            ioHist.push_back(io_in);
            if (ioHist.size() > SYNC) void'(ioHist.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        data_t exp;
        reset = 1'b1; bus.write = 1'b0; bus.MAR = '0; bus.MBR_W = '0;
        io_in = 32'h5A5A_A5A5; load_en = 1'b0; load_addr = '0; load_data = '0;
        step();
        load_en = 1'b1; load_addr = 16'h0000; load_data = 32'h1200_0005; step();
        load_addr = 16'h0001; load_data = 32'h0A0A_0A0A; step();
        load_addr = 16'h0041; load_data = 32'h4141_4141; step();
        load_addr = 16'hFFF0; load_data = 32'hFFFF_FFFF; step();
        load_en = 1'b0; step();
        checkCnt++;
        if (io_out !== 32'h0) begin errCnt++; $display("FAIL reset_io_out: got %h want 0", io_out); end
        checkCnt++;
        if (io_out_valid !== 1'b0) begin errCnt++; $display("FAIL reset_valid: got %b want 0", io_out_valid); end
        bus.MAR = ADDR_CYCLES; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h0) begin errCnt++; $display("FAIL reset_cycles: got %h want 0", bus.MBR_R); end
        bus.MAR = ADDR_STORES; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h0) begin errCnt++; $display("FAIL reset_stores: got %h want 0", bus.MBR_R); end
        bus.MAR = ADDR_IO_IN; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h0) begin errCnt++; $display("FAIL reset_sync: got %h want 0", bus.MBR_R); end
        reset = 1'b0;
        bus.MAR = 16'h0000; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h1200_0005) begin errCnt++; $display("FAIL load_ram0: got %h want 12000005", bus.MBR_R); end
        bus.MAR = 16'h0001; #1;
        void'(expRead(16'h0001, exp));
        checkCnt++;
        if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL load_ram1: got %h want %h", bus.MBR_R, exp); end
    endtask

    task automatic test_store_edge();
        data_t exp;
        bus.MAR = 16'h0040; bus.MBR_W = 32'hDEAD_BEEF; bus.write = 1'b0;
        step();
        bus.write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.MAR = ADDR_STORES; #1;
            checkCnt++;
            if (bus.MBR_R !== mStores) begin errCnt++; $display("FAIL held_store_cnt[%0d]: got %h want %h", i, bus.MBR_R, mStores); end
            bus.MAR = 16'h0040; #1;
        end
        checkCnt++;
        if (bus.MBR_R !== 32'hDEAD_BEEF) begin errCnt++; $display("FAIL store_ram40: got %h want deadbeef", bus.MBR_R); end
        bus.MAR = 16'h0041; bus.MBR_W = 32'h1111_1111;
        step(); step();
        void'(expRead(16'h0041, exp));
        checkCnt++;
        if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL held_no_rearm_ram41: got %h want %h", bus.MBR_R, exp); end
        bus.MAR = ADDR_STORES; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h1) begin errCnt++; $display("FAIL held_store_total: got %h want 1", bus.MBR_R); end
        bus.write = 1'b0;
        step();
    endtask

    task automatic test_out();
        data_t exp;
        int    pulses;
        pulses = 0;
        bus.MAR = ADDR_IO_OUT; bus.MBR_W = 32'h0000_0055; bus.write = 1'b0;
        step();
        bus.write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (io_out_valid === 1'b1) pulses++;
            checkCnt++;
            if (io_out_valid !== mValid) begin errCnt++; $display("FAIL out_valid[%0d]: got %b want %b", i, io_out_valid, mValid); end
        end
        checkCnt++;
        if (pulses != 1) begin errCnt++; $display("FAIL out_pulse_count: got %0d want 1", pulses); end
        checkCnt++;
        if (io_out !== 32'h55) begin errCnt++; $display("FAIL out_value: got %h want 55", io_out); end
        bus.write = 1'b0;
        step();
        #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h55) begin errCnt++; $display("FAIL out_readback: got %h want 55", bus.MBR_R); end
        bus.MAR = 16'hFFF4; #1;
        void'(expRead(16'hFFF4, exp));
        checkCnt++;
        if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL unmapped_read: got %h want %h", bus.MBR_R, exp); end
    endtask

    task automatic test_sync();
        data_t exp;
        bus.MAR = ADDR_IO_IN; bus.write = 1'b0;
        io_in = 32'h1357_2468;
        for (int i = 0; i < int'(SYNC) + 1; i++) step();
        io_in = 32'hCAFE_0001;
        for (int i = 0; i < int'(SYNC) + 2; i++) begin
            void'(expRead(ADDR_IO_IN, exp));
            checkCnt++;
            if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL sync_lag[%0d]: got %h want %h", i, bus.MBR_R, exp); end
            step();
        end
        checkCnt++;
        if (bus.MBR_R !== 32'hCAFE_0001) begin errCnt++; $display("FAIL sync_final: got %h want cafe0001", bus.MBR_R); end
    endtask

    task automatic test_conflict();
        data_t exp;
        bus.write = 1'b0; step();
        load_en = 1'b1; load_addr = 16'h0010; load_data = 32'h1;
        bus.MAR = 16'h0010; bus.MBR_W = 32'h2; bus.write = 1'b1;
        step();
        load_en = 1'b0;
        checkCnt++;
        if (bus.MBR_R !== 32'h1) begin errCnt++; $display("FAIL conflict_loader_wins: got %h want 1", bus.MBR_R); end
        bus.MAR = ADDR_STORES; #1;
        checkCnt++;
        if (bus.MBR_R !== mStores) begin errCnt++; $display("FAIL conflict_store_cnt: got %h want %h", bus.MBR_R, mStores); end
        bus.write = 1'b0; step();
        bus.MAR = ADDR_CYCLES; bus.MBR_W = 32'hFFFF_FFFF; bus.write = 1'b1;
        step();
        void'(expRead(ADDR_CYCLES, exp));
        checkCnt++;
        if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL ro_cycles_write: got %h want %h", bus.MBR_R, exp); end
        bus.MAR = ADDR_STORES; #1;
        checkCnt++;
        if (bus.MBR_R !== mStores) begin errCnt++; $display("FAIL ro_store_cnt: got %h want %h", bus.MBR_R, mStores); end
        bus.write = 1'b0; step();
    endtask

    task automatic test_random();
        data_t exp;
        addr_t pick;
        bus.write = 1'b0; load_en = 1'b1;
        for (int a = 16'h20; a < 16'h30; a++) begin
            load_addr = addr_t'(a); load_data = $urandom; step();
        end
        load_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.write = 1'($urandom_range(0, 1));
            pick = ($urandom_range(0, 2) == 0) ? addr_t'(16'hFFF0 + $urandom_range(0, 5))
                                               : addr_t'(16'h20 + $urandom_range(0, 15));
            bus.MAR   = pick;
            bus.MBR_W = $urandom;
            io_in     = $urandom;
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = ($urandom_range(0, 4) == 0) ? 16'hFFF8 : addr_t'(16'h20 + $urandom_range(0, 15));
            load_data = $urandom;
            #1;
            if (expRead(pick, exp)) begin
                checkCnt++;
                if (bus.MBR_R !== exp) begin errCnt++; $display("FAIL rand_read[%0d] addr %h: got %h want %h", i, pick, bus.MBR_R, exp); end
            end
            step();
            checkCnt++;
            if (io_out !== mIoOut || io_out_valid !== mValid) begin
                errCnt++;
                $display("FAIL rand_out[%0d]: got %h/%b want %h/%b", i, io_out, io_out_valid, mIoOut, mValid);
            end
        end
        load_en = 1'b0; bus.write = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; bus.write = 1'b0; step();
        reset = 1'b0;
        bus.MAR = ADDR_IO_OUT; bus.MBR_W = 32'h77;
        for (int i = 0; i < 98; i++) step();
        bus.write = 1'b1; step();
        checkCnt++;
        if (io_out_valid !== 1'b1 || io_out !== 32'h77) begin errCnt++; $display("FAIL mid_out_store: got %h/%b want 77/1", io_out, io_out_valid); end
        bus.MAR = ADDR_CYCLES; step();
        checkCnt++;
        if (bus.MBR_R !== 32'd100) begin errCnt++; $display("FAIL mid_cycles_100: got %0d want 100", bus.MBR_R); end
        bus.write = 1'b0; step();
        bus.MAR = 16'h0000; bus.MBR_W = 32'hBAD0_BAD0; bus.write = 1'b1; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        checkCnt++;
        if (bus.MBR_R !== 32'h1200_0005) begin errCnt++; $display("FAIL mid_ram0_kept: got %h want 12000005", bus.MBR_R); end
        bus.MAR = 16'h0001; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h0A0A_0A0A) begin errCnt++; $display("FAIL mid_ram1_kept: got %h want 0a0a0a0a", bus.MBR_R); end
        bus.MAR = ADDR_STORES; #1;
        checkCnt++;
        if (bus.MBR_R !== 32'h0) begin errCnt++; $display("FAIL mid_no_store: got %h want 0", bus.MBR_R); end
        bus.MAR = ADDR_CYCLES; #1;
        checkCnt++;
        if (bus.MBR_R !== mCycles) begin errCnt++; $display("FAIL mid_cycles_restart: got %h want %h", bus.MBR_R, mCycles); end
        checkCnt++;
        if (io_out !== 32'h0 || io_out_valid !== 1'b0) begin errCnt++; $display("FAIL mid_io_cleared: got %h/%b want 0/0", io_out, io_out_valid); end
    endtask

    initial begin
        test_reset();
        test_store_edge();
        test_out();
        test_sync();
        test_conflict();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, errCnt);
        $finish;
    end

endmodule
